// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin over WIDTH cycles, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, sr_q, sr_d;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, br_d;
  logic             bout_q;
  logic             d_bit;
  logic             accept;
  logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
    accept   = start && (state_q != RUN);
    last_bit = (state_q == RUN) && (cnt_q == LAST);
  end

  // Single full-subtractor cell on the current LSBs.
  always_comb begin
    d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
    br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    sr_d  = {d_bit, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q   <= '0;
      sb_q   <= '0;
      sr_q   <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      sa_q  <= a;
      sb_q  <= b;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      sa_q  <= sa_q >> 1;
      sb_q  <= sb_q >> 1;
      sr_q  <= sr_d;
      br_q  <= br_d;
      cnt_q <= cnt_q + 1'b1;
      if (last_bit) begin
        diff_q <= sr_d;
        bout_q <= br_d;
`ifdef SERIAL_SUB_OVF_EN
        // br_q here is the borrow into the MSB; br_d is the borrow out of it.
        ovf_q  <= br_q ^ br_d;
`endif
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
